// File: rtl/down_counter.sv
// Loadable down-counter: counts dec events from a loaded value to zero, pulses done
// on expiry and flags decrements past zero. Option macro: DOWN_COUNTER_WRAP_EN.
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             done,
    output logic             underflow,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO_C = '0;
    localparam logic [WIDTH-1:0] CNT_ONE_C  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX_C  = '1;

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic             zero_r;
    logic             done_r;
    logic             underflow_r;

    // Counter FSM: clr beats load beats dec; zero is kept in step with every count write.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_IDLE;
            count_r     <= CNT_ZERO_C;
            zero_r      <= 1'b1;
            done_r      <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (clr) begin
                state_r     <= ST_IDLE;
                count_r     <= CNT_ZERO_C;
                zero_r      <= 1'b1;
                underflow_r <= 1'b0;
            end else if (load) begin
                count_r <= load_val;
                zero_r  <= (load_val == CNT_ZERO_C);
                state_r <= (load_val == CNT_ZERO_C) ? ST_EXPIRED : ST_RUN;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (dec) begin
                            count_r <= count_r - CNT_ONE_C;
                            if (count_r == CNT_ONE_C) begin
                                zero_r  <= 1'b1;
                                done_r  <= 1'b1;
                                state_r <= ST_EXPIRED;
                            end else begin
                                zero_r  <= 1'b0;
                                state_r <= ST_RUN;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_EXPIRED: begin
                        if (dec) begin
                            underflow_r <= 1'b1;
`ifdef DOWN_COUNTER_WRAP_EN
                            count_r <= CNT_MAX_C;
                            zero_r  <= 1'b0;
                            state_r <= ST_RUN;
`else
                            count_r <= CNT_ZERO_C;
                            zero_r  <= 1'b1;
                            state_r <= ST_EXPIRED;
`endif
                        end else begin
                            state_r <= ST_EXPIRED;
                        end
                    end
                    // Encoding 3 is unreachable; fall back to a clean idle counter.
                    default: begin
                        state_r <= ST_IDLE;
                        count_r <= CNT_ZERO_C;
                        zero_r  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign out       = count_r;
    assign zero      = zero_r;
    assign done      = done_r;
    assign underflow = underflow_r;
    assign state     = state_r;

endmodule

// File: tb/tb_down_counter.sv
// Table-driven, scoreboarded bench for down_counter (WIDTH=8); honours DOWN_COUNTER_WRAP_EN.
module tb_down_counter;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       dec = 1'b0;
    logic [7:0] out;
    logic       zero;
    logic       done;
    logic       underflow;
    logic [1:0] state;

    down_counter #(.WIDTH(8)) dut (
        .aclk(aclk), .arst(arst), .clr(clr), .load(load), .load_val(load_val),
        .dec(dec), .out(out), .zero(zero), .done(done), .underflow(underflow),
        .state(state)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       dec;
        logic [7:0] e_out;
        logic       e_zero;
        logic       e_done;
        logic       e_uf;
        logic [1:0] e_state;
    } vec_t;

    // expected outputs packed as {out, zero, done, underflow, state}
    logic [12:0] sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[18];

    function automatic vec_t mk(input logic c, input logic l, input logic [7:0] v, input logic d,
                                input logic [7:0] eo, input logic ez, input logic ed,
                                input logic eu, input logic [1:0] es);
        vec_t t;
        t.clr = c; t.load = l; t.lv = v; t.dec = d;
        t.e_out = eo; t.e_zero = ez; t.e_done = ed; t.e_uf = eu; t.e_state = es;
        return t;
    endfunction

    task automatic compare(input string name, input logic [12:0] act, input logic [12:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got out=%0d zero=%0b done=%0b uf=%0b state=%0d, want out=%0d zero=%0b done=%0b uf=%0b state=%0d",
                     name, act[12:5], act[4], act[3], act[2], act[1:0],
                     exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
        end
    endtask

    // drive one cycle of stimulus at the falling edge, push the expectation, check after the rising edge
    task automatic apply(input string name, input vec_t v);
        logic [12:0] exp_v;
        @(negedge aclk);
        clr = v.clr; load = v.load; load_val = v.lv; dec = v.dec;
        sb_q.push_back({v.e_out, v.e_zero, v.e_done, v.e_uf, v.e_state});
        @(posedge aclk);
        #1;
        exp_v = sb_q.pop_front();
        compare(name, {out, zero, done, underflow, state}, exp_v);
        clr = 1'b0; load = 1'b0; dec = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] uf_out;
        logic       uf_zero;
        logic [1:0] uf_state;
        int         done_seen;
        int         done_at;
`ifdef DOWN_COUNTER_WRAP_EN
        uf_out = 8'hFF; uf_zero = 1'b0; uf_state = 2'd1;
`else
        uf_out = 8'h00; uf_zero = 1'b1; uf_state = 2'd2;
`endif
        //                clr   load  lv      dec   out     zero  done  uf    state
        vecs[0]  = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 2'd0);
        vecs[1]  = mk(1'b0, 1'b1, 8'd3,   1'b0, 8'd3,   1'b0, 1'b0, 1'b0, 2'd1);
        vecs[2]  = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   1'b0, 1'b0, 1'b0, 2'd1);
        vecs[3]  = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 2'd1);
        vecs[4]  = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 2'd2);
        vecs[5]  = mk(1'b0, 1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 2'd2);
        vecs[6]  = mk(1'b0, 1'b0, 8'd0,   1'b1, uf_out, uf_zero, 1'b0, 1'b1, uf_state);
        vecs[7]  = mk(1'b0, 1'b1, 8'd5,   1'b0, 8'd5,   1'b0, 1'b0, 1'b1, 2'd1);
        vecs[8]  = mk(1'b0, 1'b1, 8'd9,   1'b1, 8'd9,   1'b0, 1'b0, 1'b1, 2'd1);
        vecs[9]  = mk(1'b1, 1'b1, 8'd7,   1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 2'd0);
        vecs[10] = mk(1'b0, 1'b1, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 2'd2);
        vecs[11] = mk(1'b0, 1'b0, 8'd0,   1'b1, uf_out, uf_zero, 1'b0, 1'b1, uf_state);
        vecs[12] = mk(1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 2'd0);
        vecs[13] = mk(1'b0, 1'b1, 8'd1,   1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 2'd1);
        vecs[14] = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 2'd2);
        vecs[15] = mk(1'b0, 1'b1, 8'd255, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 2'd1);
        vecs[16] = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd254, 1'b0, 1'b0, 1'b0, 2'd1);
        vecs[17] = mk(1'b0, 1'b0, 8'd0,   1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 2'd1);

        // reset values
        #100;
        compare("reset_hold", {out, zero, done, underflow, state}, {8'd0, 1'b1, 1'b0, 1'b0, 2'd0});
        @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk);
        #1;
        compare("reset_release", {out, zero, done, underflow, state}, {8'd0, 1'b1, 1'b0, 1'b0, 2'd0});

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // held dec: done must land exactly V=4 cycles after the first dec edge
        apply("hold_load4", mk(1'b0, 1'b1, 8'd4, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 2'd1));
        done_seen = 0;
        done_at   = -1;
        @(negedge aclk);
        dec = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge aclk);
            #1;
            if (done === 1'b1) begin
                done_seen++;
                if (done_at < 0) done_at = c;
            end
        end
        @(negedge aclk);
        dec = 1'b0;
        compare("hold_done_cycle", {5'd0, done_at[7:0]}, {5'd0, 8'd4});
        compare("hold_done_count", {5'd0, done_seen[7:0]}, {5'd0, 8'd1});

        // reset mid-count: asynchronous clear between edges
        apply("mid_load200", mk(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0));
        apply("mid_load200b", mk(1'b0, 1'b1, 8'd200, 1'b0, 8'd200, 1'b0, 1'b0, 1'b0, 2'd1));
        for (int k = 1; k <= 50; k++) begin
            apply($sformatf("mid_dec%0d", k),
                  mk(1'b0, 1'b0, 8'd0, 1'b1, 8'(200 - k), 1'b0, 1'b0, 1'b0, 2'd1));
        end
        @(negedge aclk);
        #2;
        arst = 1'b1;
        #1;
        compare("async_reset", {out, zero, done, underflow, state}, {8'd0, 1'b1, 1'b0, 1'b0, 2'd0});
        #1;
        arst = 1'b0;
        apply("post_reset_dec", mk(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
